// File: rtl/game2048_pkg.sv
// ============================================================================
// Package     : game2048_pkg
// Description : Shared types and constants for the 2048 move engine: tile and
//               board types, one-hot direction codes and scheduler states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game2048_pkg;

  localparam int DEF_TILE_W    = 12;
  localparam int DEF_SCORE_W   = 20;
  localparam int DEF_WIN_VALUE = 2048;

  typedef logic [DEF_TILE_W-1:0] tile_t;
  // board[row][col]
  typedef tile_t [3:0][3:0] board_t;

  localparam logic [3:0] DIR_TOP    = 4'b0001;
  localparam logic [3:0] DIR_BOTTOM = 4'b0010;
  localparam logic [3:0] DIR_LEFT   = 4'b0100;
  localparam logic [3:0] DIR_RIGHT  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LINE = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/line_merge.sv
// ============================================================================
// Module      : line_merge
// Description : Combinational slide/merge of one 4-tile line toward element 0.
//               Non-zero tiles are compacted first, then equal neighbours are
//               merged once each, scanning from element 0.
// Ports       : line_i  - 4 input tiles, element 0 at the destination edge
//               line_o  - 4 result tiles
//               score_o - sum of the values produced by merges in this line
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_merge #(
  parameter int TILE_W = 12
) (
  input  logic [3:0][TILE_W-1:0] line_i,
  output logic [3:0][TILE_W-1:0] line_o,
  output logic [TILE_W+1:0]      score_o
);

  // One spare zero entry so the pair look-ahead at element 3 stays in range.
  logic [4:0][TILE_W-1:0] w_comp;
  logic [2:0]             w_wr;
  logic [2:0]             w_wo;
  logic                   w_skip;
  logic [TILE_W:0]        w_sum;

  always_comb begin
    w_comp  = '0;
    w_wr    = '0;
    w_wo    = '0;
    w_skip  = 1'b0;
    w_sum   = '0;
    line_o  = '0;
    score_o = '0;

    for (int j = 0; j < 4; j++) begin
      if (line_i[j] != '0) begin
        w_comp[w_wr] = line_i[j];
        w_wr         = w_wr + 3'd1;
      end
    end

    for (int j = 0; j < 4; j++) begin
      w_sum = {1'b0, w_comp[j]} + {1'b0, w_comp[j+1]};
      if (w_skip) begin
        // Second tile of a pair already consumed by a merge.
        w_skip = 1'b0;
      end else if ((w_comp[j] != '0) && (w_comp[j] == w_comp[j+1]) && !w_sum[TILE_W]) begin
        // Merges that would overflow the tile width are inhibited.
        line_o[w_wo[1:0]] = w_sum[TILE_W-1:0];
        score_o           = score_o + {1'b0, w_sum};
        w_wo              = w_wo + 3'd1;
        w_skip            = 1'b1;
      end else begin
        line_o[w_wo[1:0]] = w_comp[j];
        w_wo              = w_wo + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/move_merge_scheduler.sv
// ============================================================================
// Module      : move_merge_scheduler
// Description : Time-multiplexes one line_merge datapath across the four lines
//               of the 4x4 board, one line per clock, for a single move.
// Ports       : clk_i         - clock, rising edge
//               rst_ni        - asynchronous active-low reset
//               start_i       - move request, sampled in IDLE only
//               direction_i   - one-hot: 0001 top, 0010 bottom, 0100 left,
//                               1000 right
//               board_in_i    - board snapshot, sampled on accepted start
//               busy_o        - move in progress
//               done_o        - one-cycle pulse, results valid from here on
//               board_out_o   - moved and merged board
//               score_delta_o - sum of merged tile values (saturating)
//               moved_o       - result differs from the sampled board
//               win_tile_o    - some result tile >= WIN_VALUE
//               dir_err_o     - one-cycle pulse on start with bad direction
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_merge_scheduler
  import game2048_pkg::*;
#(
  parameter int TILE_W    = DEF_TILE_W,
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int WIN_VALUE = DEF_WIN_VALUE
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [3:0]                     direction_i,
  input  logic [3:0][3:0][TILE_W-1:0]    board_in_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [3:0][3:0][TILE_W-1:0]    board_out_o,
  output logic [SCORE_W-1:0]             score_delta_o,
  output logic                           moved_o,
  output logic                           win_tile_o,
  output logic                           dir_err_o
);

  localparam logic [TILE_W:0] C_WIN = (TILE_W+1)'(WIN_VALUE);

  sched_state_e                  state_q;
  logic [1:0]                    line_q;
  logic [3:0]                    dir_q;
  logic [3:0][3:0][TILE_W-1:0]   work_q;
  logic [3:0][3:0][TILE_W-1:0]   orig_q;
  logic [SCORE_W-1:0]            acc_q;

  logic [3:0][TILE_W-1:0]        line_in_d;
  logic [3:0][TILE_W-1:0]        line_out;
  logic [TILE_W+1:0]             line_score;
  logic [3:0][3:0][TILE_W-1:0]   work_d;
  logic [SCORE_W:0]              acc_sum;
  logic [SCORE_W-1:0]            acc_d;
  logic                          win_any;

  // Gather line line_q with element 0 at the edge tiles slide toward.
  always_comb begin
    line_in_d = '0;
    for (int e = 0; e < 4; e++) begin
      case (dir_q)
        DIR_RIGHT:  line_in_d[e] = work_q[line_q][2'(3-e)];
        DIR_TOP:    line_in_d[e] = work_q[2'(e)][line_q];
        DIR_BOTTOM: line_in_d[e] = work_q[2'(3-e)][line_q];
        default:    line_in_d[e] = work_q[line_q][2'(e)];
      endcase
    end
  end

  line_merge #(
    .TILE_W (TILE_W)
  ) u_line_merge (
    .line_i  (line_in_d),
    .line_o  (line_out),
    .score_o (line_score)
  );

  // Scatter the merged line back in the same orientation it was gathered.
  always_comb begin
    work_d = work_q;
    for (int e = 0; e < 4; e++) begin
      case (dir_q)
        DIR_RIGHT:  work_d[line_q][2'(3-e)] = line_out[e];
        DIR_TOP:    work_d[2'(e)][line_q]   = line_out[e];
        DIR_BOTTOM: work_d[2'(3-e)][line_q] = line_out[e];
        default:    work_d[line_q][2'(e)]   = line_out[e];
      endcase
    end
  end

  always_comb begin
    acc_sum = {1'b0, acc_q} + (SCORE_W+1)'(line_score);
    acc_d   = acc_sum[SCORE_W] ? '1 : acc_sum[SCORE_W-1:0];
  end

  always_comb begin
    win_any = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if ({1'b0, work_q[r][c]} >= C_WIN) begin
          win_any = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      line_q        <= '0;
      dir_q         <= '0;
      work_q        <= '0;
      orig_q        <= '0;
      acc_q         <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      board_out_o   <= '0;
      score_delta_o <= '0;
      moved_o       <= 1'b0;
      win_tile_o    <= 1'b0;
      dir_err_o     <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      dir_err_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if ($onehot(direction_i)) begin
              work_q  <= board_in_i;
              orig_q  <= board_in_i;
              dir_q   <= direction_i;
              acc_q   <= '0;
              line_q  <= '0;
              busy_o  <= 1'b1;
              state_q <= ST_LINE;
            end else begin
              dir_err_o <= 1'b1;
            end
          end
        end
        ST_LINE: begin
          work_q <= work_d;
          acc_q  <= acc_d;
          line_q <= line_q + 2'd1;
          if (line_q == 2'd3) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_o        <= 1'b1;
          board_out_o   <= work_q;
          score_delta_o <= acc_q;
          moved_o       <= (work_q != orig_q);
          win_tile_o    <= win_any;
          busy_o        <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
